// File: rtl/sram_arbiter_if.sv
// Bus bundle for the SRAM arbiter: fetch port, data port and external SRAM pins.
// The arbiter uses the slave modport; the environment drives through master.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              freeze;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_we_n;
  logic              sram_oe_n;

  modport slave (
    input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );

  modport master (
    output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_addr, sram_wdata, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and the LDR/STR stage.
// Data wins over fetch, except a waiting fetch is served right after a data grant.
//
//   state  | meaning
//   IDLE   | no access in progress, arbitration happens here
//   DATA   | data read/write access running on the SRAM
//   INST   | instruction fetch access running on the SRAM
//   RESP   | one-cycle completion, ready pulse for the finished access
module sram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 3
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_INST, S_RESP} state_t;
  typedef enum logic [1:0] {K_READ, K_WRITE, K_FETCH} kind_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_data_q, last_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              data_req;
  logic              mem_ready;

  assign data_req = bus.mem_r_en | bus.mem_w_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      kind_q      <= K_READ;
      cnt_q       <= 4'd0;
      last_data_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      S_IDLE: begin
        we_n_d = 1'b1;
        oe_n_d = 1'b1;
        // A fetch left waiting behind a data grant goes first on a tie.
        if (data_req && (!bus.if_req || !last_data_q)) begin
          state_d     = S_DATA;
          cnt_d       = CNT_INIT;
          last_data_d = 1'b1;
          addr_d      = bus.mem_addr;
          if (bus.mem_w_en) begin
            kind_d  = K_WRITE;
            wdata_d = bus.mem_wdata;
            we_n_d  = 1'b0;
          end else begin
            kind_d  = K_READ;
            oe_n_d  = 1'b0;
          end
        end else if (bus.if_req) begin
          state_d     = S_INST;
          kind_d      = K_FETCH;
          cnt_d       = CNT_INIT;
          last_data_d = 1'b0;
          addr_d      = bus.if_addr;
          oe_n_d      = 1'b0;
        end
      end
      S_DATA, S_INST: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (kind_q == K_READ)  mem_rdata_d = bus.sram_rdata;
          if (kind_q == K_FETCH) if_rdata_d  = bus.sram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
      end
    endcase
  end

  assign mem_ready      = (state_q == S_RESP) && (kind_q != K_FETCH);
  assign bus.mem_ready  = mem_ready;
  assign bus.if_ready   = (state_q == S_RESP) && (kind_q == K_FETCH);
  assign bus.freeze     = data_req & ~mem_ready;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single-port external SRAM between the instruction-fetch stage and the memory stage (LDR/STR) of the ARM pipeline. It grants one access at a time, runs the fixed-latency SRAM access sequence, and returns read data with a one-cycle ready pulse. It drives `freeze` to hold the whole pipeline while a data access is outstanding. Data accesses win over fetches, except that after a data grant a waiting fetch is served next.

## Interface
- `ADDR_W`, 32: address width for both requesters and the SRAM.
- `DATA_W`, 32: data width.
- `WAIT_CYCLES`, 3: SRAM access cycles per transfer; legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched instruction, held until the next fetch completes.
- `if_ready`  out  1  one-cycle pulse when `if_rdata` is valid.
- `mem_r_en`  in  1  data read request (LDR).
- `mem_w_en`  in  1  data write request (STR).
- `mem_addr`  in  ADDR_W  data address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_rdata`  out  DATA_W  load data, held until the next data read completes.
- `mem_ready`  out  1  one-cycle pulse when a data access completes.
- `freeze`  out  1  pipeline stall.
- `sram_addr`  out  ADDR_W  SRAM address.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data.
- `sram_we_n`  out  1  SRAM write enable, active-low.
- `sram_oe_n`  out  1  SRAM output enable, active-low.

## Operation
- States:
  - IDLE: no access in progress.
  - DATA: data access in progress.
  - INST: fetch access in progress.
  - RESP: one-cycle completion state.
- Registers:
  - 4-bit `cnt`.
  - `last_data`: set when the last grant was a data access.
  - Latched address, write data and type: read, write or fetch.
- Arbitration, evaluated only in IDLE:
  - Data request alone (`mem_r_en|mem_w_en`) -> DATA.
  - `if_req` alone -> INST.
  - Both pending: INST if `last_data`=1, else DATA.
  - Neither pending: stay in IDLE.
- On a grant:
  - Latch the address, plus `mem_wdata` for a write.
  - Set `cnt`=WAIT_CYCLES-1.
  - Update `last_data`.
- `mem_r_en` and `mem_w_en` both high: treated as a write; the read is ignored.
- DATA/INST:
  - `sram_addr` = latched address.
  - Read or fetch: `sram_oe_n`=0.
  - Write: `sram_we_n`=0 and `sram_wdata` = latched data.
  - `cnt` decrements each cycle.
  - When `cnt`=0: capture `sram_rdata` into `mem_rdata` (data read) or `if_rdata` (fetch), then go to RESP. A write captures nothing.
- RESP:
  - `mem_ready`=1 if the access was data, `if_ready`=1 if it was a fetch.
  - `sram_we_n`=`sram_oe_n`=1.
  - Next state is always IDLE. Requests are not sampled in RESP.
- Requesters must hold address and data stable until ready. A request still asserted in the following IDLE cycle counts as a new request.
- `freeze` = (`mem_r_en`|`mem_w_en`) & ~`mem_ready`. It is combinational and does not depend on `if_req`.

## Timing
- Reset values:
  - State: IDLE.
  - `cnt`=0, `last_data`=0.
  - `sram_addr`=0, `sram_wdata`=0.
  - `sram_we_n`=1, `sram_oe_n`=1.
  - `if_rdata`=0, `mem_rdata`=0.
  - `if_ready`=0, `mem_ready`=0.
  - `freeze` follows its equation.
- Reset asserted mid-access:
  - The access aborts immediately (asynchronously).
  - `sram_we_n`/`sram_oe_n` return to 1.
  - No ready pulse is generated.
- Latency: a request sampled in IDLE at edge N gives the access state from N+1 to N+WAIT_CYCLES and ready high for cycle N+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- All SRAM outputs are registered. `sram_we_n`/`sram_oe_n` are low for exactly WAIT_CYCLES cycles per access.
- WAIT_CYCLES=1: `cnt` loads 0 and the access state lasts a single cycle.
- Ready outputs are registered state decodes; no combinational path from inputs to ready.

## Test plan
- Reset, no requests:
  - `sram_we_n`=`sram_oe_n`=1 and both ready outputs stay 0.
  - `freeze`=0.
- Single fetch, `if_addr`=0x40, SRAM returns 0xE3A01005, WAIT_CYCLES=3:
  - `sram_oe_n` low for 3 cycles.
  - `if_ready` high exactly on the 4th cycle after the request edge, with `if_rdata`=0xE3A01005.
- STR with `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF:
  - `sram_we_n` low for 3 cycles with that address and data.
  - `mem_ready` pulses once; `freeze` is 1 until that pulse cycle.
  - `mem_rdata` is unchanged.
- `if_req` and `mem_r_en` asserted together from IDLE with `last_data`=0:
  - Data is served first.
  - The fetch is granted in the following IDLE cycle even if a new data request is present.
- `mem_r_en`=`mem_w_en`=1: only a write occurs (`sram_oe_n` stays 1).
- `rst` pulled low during the 2nd access cycle of a write:
  - `sram_we_n`=1 immediately and no ready pulse.
  - After reset release, a held `mem_r_en` is served normally.
